// File: rtl/wb_stage_dual.sv
// Dual-issue writeback stage: writes both lanes of a captured pair into the
// 2-port regfile in one cycle, then replays them one per cycle on the debug trace.
module wb_stage_dual #(
    parameter int LANE_W        = 71,
    parameter bit GATE_ZERO_DST = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ms_to_ws_valid,
    input  logic [2*LANE_W-1:0]   ms_to_ws_bus,
    output logic                  ws_allowin,
    output logic                  rf_we_01,
    output logic [4:0]            rf_waddr_01,
    output logic [31:0]           rf_wdata_01,
    output logic                  rf_we_02,
    output logic [4:0]            rf_waddr_02,
    output logic [31:0]           rf_wdata_02,
    output logic [31:0]           debug_wb_pc,
    output logic [3:0]            debug_wb_rf_wen,
    output logic [4:0]            debug_wb_rf_wnum,
    output logic [31:0]           debug_wb_rf_wdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_L0   = 2'd1,
        S_L1   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 first_q, first_d;
    logic [2*LANE_W-1:0]  ws_bus_q, ws_bus_d;

    logic [LANE_W-1:0]    lane0, lane1;
    logic                 in_l0_valid, in_l1_valid;
    logic                 accept;
    logic                 l0_zero_dst, l1_zero_dst;

    assign lane0       = ws_bus_q[LANE_W-1:0];
    assign lane1       = ws_bus_q[2*LANE_W-1:LANE_W];
    assign in_l0_valid = ms_to_ws_bus[70];
    assign in_l1_valid = ms_to_ws_bus[LANE_W+70];

    // L0 only blocks a new pair while lane1 still owes a trace beat
    assign ws_allowin = (state_q == S_IDLE) || (state_q == S_L1) ||
                        ((state_q == S_L0) && !lane1[70]);
    assign accept     = ms_to_ws_valid && ws_allowin && (in_l0_valid || in_l1_valid);

    always_comb begin
        state_d  = S_IDLE;
        first_d  = accept;
        ws_bus_d = ws_bus_q;
        if (accept) begin
            ws_bus_d = ms_to_ws_bus;
            state_d  = in_l0_valid ? S_L0 : S_L1;
        end else if ((state_q == S_L0) && lane1[70]) begin
            state_d  = S_L1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            first_q  <= 1'b0;
            ws_bus_q <= '0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            ws_bus_q <= ws_bus_d;
        end
    end

    assign l0_zero_dst = GATE_ZERO_DST && (lane0[68:64] == 5'd0);
    assign l1_zero_dst = GATE_ZERO_DST && (lane1[68:64] == 5'd0);

    // Both lanes are written only in the cycle right after capture
    assign rf_we_01    = first_q && lane0[70] && lane0[69] && !l0_zero_dst;
    assign rf_waddr_01 = lane0[68:64];
    assign rf_wdata_01 = lane0[31:0];
    assign rf_we_02    = first_q && lane1[70] && lane1[69] && !l1_zero_dst;
    assign rf_waddr_02 = lane1[68:64];
    assign rf_wdata_02 = lane1[31:0];

    always_comb begin
        debug_wb_pc       = 32'd0;
        debug_wb_rf_wen   = 4'd0;
        debug_wb_rf_wnum  = 5'd0;
        debug_wb_rf_wdata = 32'd0;
        case (state_q)
            S_L0: begin
                debug_wb_pc       = lane0[63:32];
                debug_wb_rf_wen   = {4{lane0[69]}};
                debug_wb_rf_wnum  = lane0[68:64];
                debug_wb_rf_wdata = lane0[31:0];
            end
            S_L1: begin
                debug_wb_pc       = lane1[63:32];
                debug_wb_rf_wen   = {4{lane1[69]}};
                debug_wb_rf_wnum  = lane1[68:64];
                debug_wb_rf_wdata = lane1[31:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_stage_dual.sv
// Bench for wb_stage_dual: directed scenarios plus random pairs, checked against
// a queue-of-commits reference model and a program-order regfile model.
module tb_wb_stage_dual;

    typedef struct packed {
        logic        v;
        logic        we;
        logic [4:0]  d;
        logic [31:0] pc;
        logic [31:0] res;
    } lane_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          ms_to_ws_valid;
    logic [141:0]  ms_to_ws_bus;
    logic          ws_allowin;
    logic          rf_we_01, rf_we_02;
    logic [4:0]    rf_waddr_01, rf_waddr_02;
    logic [31:0]   rf_wdata_01, rf_wdata_02;
    logic [31:0]   debug_wb_pc;
    logic [3:0]    debug_wb_rf_wen;
    logic [4:0]    debug_wb_rf_wnum;
    logic [31:0]   debug_wb_rf_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    wb_stage_dual dut (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .ws_allowin(ws_allowin),
        .rf_we_01(rf_we_01), .rf_waddr_01(rf_waddr_01), .rf_wdata_01(rf_wdata_01),
        .rf_we_02(rf_we_02), .rf_waddr_02(rf_waddr_02), .rf_wdata_02(rf_wdata_02),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    // Regfile fed by the DUT's write ports; port 2 has priority on equal address
    logic [31:0] dut_rf [32] = '{default: 32'd0};
    always @(posedge clk) begin
        if (rf_we_01) dut_rf[rf_waddr_01] <= rf_wdata_01;
        if (rf_we_02) dut_rf[rf_waddr_02] <= rf_wdata_02;
    end

    // Reference model state
    lane_t        beats[$];
    logic [141:0] last_pair = '0;
    logic         exp_first = 1'b0;
    logic [31:0]  model_rf [32] = '{default: 32'd0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [70:0] mk_lane(input logic v, input logic we, input logic [4:0] d,
                                            input logic [31:0] pc, input logic [31:0] res);
        lane_t l;
        l.v = v; l.we = we; l.d = d; l.pc = pc; l.res = res;
        return l;
    endfunction

    // One clock: drive inputs, check outputs of the current cycle, advance the model
    task automatic step(input logic r, input logic v, input logic [141:0] b);
        lane_t l0, l1, shown;
        logic  exp_we1, exp_we2, acc;
        @(negedge clk);
        reset          = r;
        ms_to_ws_valid = v;
        ms_to_ws_bus   = b;
        #1;
        l0      = lane_t'(last_pair[70:0]);
        l1      = lane_t'(last_pair[141:71]);
        shown   = (beats.size() > 0) ? beats[0] : lane_t'(71'd0);
        exp_we1 = exp_first && l0.v && l0.we && (l0.d != 5'd0);
        exp_we2 = exp_first && l1.v && l1.we && (l1.d != 5'd0);
        check("allowin",  64'(ws_allowin),        64'(beats.size() <= 1));
        check("we_01",    64'(rf_we_01),          64'(exp_we1));
        check("we_02",    64'(rf_we_02),          64'(exp_we2));
        check("waddr_01", 64'(rf_waddr_01),       64'(l0.d));
        check("wdata_01", 64'(rf_wdata_01),       64'(l0.res));
        check("waddr_02", 64'(rf_waddr_02),       64'(l1.d));
        check("wdata_02", 64'(rf_wdata_02),       64'(l1.res));
        check("tr_pc",    64'(debug_wb_pc),       64'(shown.pc));
        check("tr_wen",   64'(debug_wb_rf_wen),   64'({4{shown.we}}));
        check("tr_wnum",  64'(debug_wb_rf_wnum),  64'(shown.d));
        check("tr_wdata", 64'(debug_wb_rf_wdata), 64'(shown.res));

        // Program order: older lane first, so the younger one lands last
        if (exp_we1) model_rf[l0.d] = l0.res;
        if (exp_we2) model_rf[l1.d] = l1.res;

        if (r) begin
            beats.delete();
            last_pair = '0;
            exp_first = 1'b0;
        end else begin
            acc = v && (beats.size() <= 1) && (b[70] || b[141]);
            if (beats.size() > 0) void'(beats.pop_front());
            exp_first = acc;
            if (acc) begin
                last_pair = b;
                if (b[70])  beats.push_back(lane_t'(b[70:0]));
                if (b[141]) beats.push_back(lane_t'(b[141:71]));
            end
        end
    endtask

    function automatic logic [70:0] rand_lane();
        logic [4:0] d;
        d = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom);
        return mk_lane(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), d,
                       $urandom, $urandom);
    endfunction

    logic [141:0] pair;

    initial begin
        reset = 1'b1; ms_to_ws_valid = 1'b0; ms_to_ws_bus = '0;
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);

        // Dual pair, then reset while lane0 is on the trace
        pair = {mk_lane(1, 1, 5'd4, 32'hBFC00004, 32'h22), mk_lane(1, 1, 5'd3, 32'hBFC00000, 32'h11)};
        step(1'b0, 1'b1, pair);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        check("rst_pc",      64'(debug_wb_pc), 64'd0);
        check("rst_allowin", 64'(ws_allowin),  64'd1);

        // Dual pair, full two-beat trace
        step(1'b0, 1'b1, pair);
        step(1'b0, 1'b1, pair);
        check("dual_pc0", 64'(debug_wb_pc), 64'hBFC00000);
        step(1'b0, 1'b0, '0);
        check("dual_pc1", 64'(debug_wb_pc), 64'hBFC00004);
        step(1'b0, 1'b0, '0);

        // Same destination in one pair: younger lane wins in the regfile
        pair = {mk_lane(1, 1, 5'd5, 32'hBFC00024, 32'hBB), mk_lane(1, 1, 5'd5, 32'hBFC00020, 32'hAA)};
        step(1'b0, 1'b1, pair);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        check("same_dst_rf5", 64'(dut_rf[5]), 64'hBB);

        // Back-to-back single-lane pairs with valid held high
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, {71'd0, mk_lane(1, 1, 5'(8 + i), 32'hBFC00100 + 32'(4 * i), 32'(i + 100))});
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);

        // Lane1-only pair
        step(1'b0, 1'b1, {mk_lane(1, 1, 5'd6, 32'hBFC00010, 32'h7), 71'd0});
        step(1'b0, 1'b0, '0);
        check("l1only_pc", 64'(debug_wb_pc), 64'hBFC00010);
        step(1'b0, 1'b0, '0);

        // Lane0 writes $0, then a pair with no valid lanes
        step(1'b0, 1'b1, {71'd0, mk_lane(1, 1, 5'd0, 32'hBFC00040, 32'h55)});
        step(1'b0, 1'b1, {mk_lane(0, 1, 5'd9, 32'hBFC00048, 32'h9), mk_lane(0, 1, 5'd8, 32'hBFC00044, 32'h8)});
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            pair = {rand_lane(), rand_lane()};
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0), pair);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);

        for (int i = 0; i < 32; i++)
            check($sformatf("rf[%0d]", i), 64'(dut_rf[i]), 64'(model_rf[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
